// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: N-core memory/coherence controller.
// Arbitrates L1 instruction fetches, data fills and writebacks onto one RAM port.
// Data fills snoop every peer first. A peer holding the block modified supplies it
// directly (cache-to-cache), and the same word is written back to RAM in that cycle.
module coherence_bus_ctrl #(
  parameter int NCPU         = 2,
  parameter int WORD_W       = 32,
  parameter int SNOOP_CYCLES = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NCPU-1:0]          iREN,
  input  logic [NCPU*WORD_W-1:0]   iaddr,
  output logic [NCPU-1:0]          iwait,
  output logic [NCPU*WORD_W-1:0]   iload,
  input  logic [NCPU-1:0]          dREN,
  input  logic [NCPU-1:0]          dWEN,
  input  logic [NCPU*WORD_W-1:0]   daddr,
  input  logic [NCPU*WORD_W-1:0]   dstore,
  output logic [NCPU-1:0]          dwait,
  output logic [NCPU*WORD_W-1:0]   dload,
  input  logic [NCPU-1:0]          ccwrite,
  input  logic [NCPU-1:0]          cctrans,
  output logic [NCPU-1:0]          ccwait,
  output logic [NCPU-1:0]          ccinv,
  output logic [NCPU*WORD_W-1:0]   ccsnoopaddr,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate
);

  localparam int GW = $clog2(NCPU);
  localparam int CW = $clog2(SNOOP_CYCLES + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_SNOOP, S_C2C, S_RAMRD, S_IFETCH
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   g, g_nxt;         // granted core
  logic [GW-1:0]   s, s_nxt;         // supplying core during C2C
  logic [GW-1:0]   dptr, dptr_nxt;   // round-robin start for data requests
  logic [GW-1:0]   iptr, iptr_nxt;   // round-robin start for instruction requests
  logic [CW-1:0]   snoop_cnt, snoop_cnt_nxt;
  logic [GW-1:0]   sup;
  logic            sup_hit;
  logic            acc;

  logic [WORD_W-1:0] daddr_g, dstore_g, iaddr_g, daddr_s, dstore_s;

  function automatic logic [GW-1:0] wrap_idx(input int v);
    return GW'(v % NCPU);
  endfunction

  // First requester at or above ptr, wrapping round.
  function automatic logic [GW-1:0] rr_pick(input logic [NCPU-1:0] req,
                                            input logic [GW-1:0]   ptr);
    logic [GW-1:0] pick;
    logic          found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NCPU; i++) begin
      if (!found && req[wrap_idx(int'(ptr) + i)]) begin
        pick  = wrap_idx(int'(ptr) + i);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign acc      = (ramstate == RAM_ACCESS);
  assign daddr_g  = daddr[int'(g)*WORD_W +: WORD_W];
  assign dstore_g = dstore[int'(g)*WORD_W +: WORD_W];
  assign iaddr_g  = iaddr[int'(g)*WORD_W +: WORD_W];
  assign daddr_s  = daddr[int'(s)*WORD_W +: WORD_W];
  assign dstore_s = dstore[int'(s)*WORD_W +: WORD_W];

  // Supplier search: first peer above the requester (wrapping) that reports M.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    sup     = g;
    sup_hit = 1'b0;
    for (int i = 1; i < NCPU; i++) begin
      if (!sup_hit && ccwrite[wrap_idx(int'(g) + i)]) begin
        sup     = wrap_idx(int'(g) + i);
        sup_hit = 1'b1;
      end
    end
  end

  // State, grant and pointer registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: registers use non-blocking assignment so all of them update together at the edge.
    if (RST) begin
      state     <= S_IDLE;
      g         <= '0;
      s         <= '0;
      dptr      <= '0;
      iptr      <= '0;
      snoop_cnt <= '0;
    end else begin
      state     <= state_nxt;
      g         <= g_nxt;
      s         <= s_nxt;
      dptr      <= dptr_nxt;
      iptr      <= iptr_nxt;
      snoop_cnt <= snoop_cnt_nxt;
    end
  end

  // Next-state: arbitration in IDLE, snoop timing, and exit conditions.
  always_comb begin
    state_nxt     = state;
    g_nxt         = g;
    s_nxt         = s;
    dptr_nxt      = dptr;
    iptr_nxt      = iptr;
    snoop_cnt_nxt = snoop_cnt;
    case (state)
      S_IDLE: begin
        snoop_cnt_nxt = '0;
        if (|dWEN) begin
          g_nxt     = rr_pick(dWEN, dptr);
          dptr_nxt  = wrap_idx(int'(rr_pick(dWEN, dptr)) + 1);
          state_nxt = S_WB;
        end else if (|dREN) begin
          g_nxt     = rr_pick(dREN, dptr);
          dptr_nxt  = wrap_idx(int'(rr_pick(dREN, dptr)) + 1);
          state_nxt = S_SNOOP;
        end else if (|iREN) begin
          g_nxt     = rr_pick(iREN, iptr);
          iptr_nxt  = wrap_idx(int'(rr_pick(iREN, iptr)) + 1);
          state_nxt = S_IFETCH;
        end
      end
      S_WB: if (!dWEN[g]) state_nxt = S_IDLE;
      S_SNOOP: begin
        if (!dREN[g]) begin
          state_nxt = S_IDLE;
        end else if (snoop_cnt == CW'(SNOOP_CYCLES - 1)) begin
          snoop_cnt_nxt = '0;
          if (sup_hit) begin
            s_nxt     = sup;
            state_nxt = S_C2C;
          end else begin
            state_nxt = S_RAMRD;
          end
        end else begin
          snoop_cnt_nxt = snoop_cnt + CW'(1);
        end
      end
      S_C2C, S_RAMRD: if (!dREN[g]) state_nxt = S_IDLE;
      S_IFETCH: if (acc || !iREN[g]) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state/grant; unselected cores see wait=1, load=0.
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    if (state == S_SNOOP || state == S_C2C || state == S_RAMRD) begin
      for (int k = 0; k < NCPU; k++) begin
        if (k != int'(g)) begin
          ccwait[k]                         = 1'b1;
          ccinv[k]                          = ccwrite[g] & cctrans[g];
          ccsnoopaddr[k*WORD_W +: WORD_W]   = daddr_g;
        end
      end
    end
    case (state)
      S_WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr_g;
        ramstore = dstore_g;
        if (acc) dwait[g] = 1'b0;
      end
      S_C2C: begin
        dload[int'(g)*WORD_W +: WORD_W] = dstore_s;
        ramWEN   = 1'b1;
        ramaddr  = daddr_s;
        ramstore = dstore_s;
        if (acc) begin
          dwait[g] = 1'b0;
          dwait[s] = 1'b0;
        end
      end
      S_RAMRD: begin
        ramREN  = 1'b1;
        ramaddr = daddr_g;
        dload[int'(g)*WORD_W +: WORD_W] = ramload;
        if (acc) dwait[g] = 1'b0;
      end
      S_IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr_g;
        iload[int'(g)*WORD_W +: WORD_W] = ramload;
        if (acc) iwait[g] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
